alu_pipe: RTL

Parametrised, pipelined signed ALU that generalises the team's 3-bit, 8-operation combinational ALU.
- Operand width is set by `W`; all arithmetic is carried at full precision, so nothing truncates.
- Operands and results move through a 2-stage valid/ready pipeline with backpressure.
- Each result carries zero and negative flags, and a wrapping count of completed operations is kept.
- The block sits between an operand producer (register file or test sequencer) and a result consumer, and can be stalled by either side.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_pipe_if.sv | 27 ++
 rtl/alu_core.sv | 46 ++++
 rtl/alu_pipe.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined signed ALU: operation encoding and
// the result-width rule used by the core, the pipeline and the interface.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AVG  = 3'b000,
    OP_DBL  = 3'b001,
    OP_XHY  = 3'b010,
    OP_HDIF = 3'b011,
    OP_NAND = 3'b100,
    OP_NOTX = 3'b101,
    OP_NOR  = 3'b110,
    OP_XOR  = 3'b111
  } alu_op_e;

  // Two guard bits cover the full range of 2*(x+y), so no result overflows.
  function automatic int res_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result bus of alu_pipe; master drives operands and accepts results.
interface alu_pipe_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [W+1:0]     result;
  logic             zero;
  logic             neg;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, x, y, op, out_ready,
    input  in_ready, out_valid, result, zero, neg, op_count
  );

  modport slave (
    input  in_valid, x, y, op, out_ready,
    output in_ready, out_valid, result, zero, neg, op_count
  );
endinterface

// File: rtl/alu_core.sv
// Combinational signed ALU: operands sign-extended to W+2 bits, logic ops
// evaluated at W bits and sign-extended afterwards.
module alu_core import alu_pkg::*; #(
  parameter int W = 8
) (
  input  logic [W-1:0]        x_i,
  input  logic [W-1:0]        y_i,
  input  logic [2:0]          op_i,
  output logic [res_w(W)-1:0] result_o,
  output logic                zero_o,
  output logic                neg_o
);
  localparam int RW = res_w(W);

  logic signed [RW-1:0] xe;
  logic signed [RW-1:0] ye;
  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] dif;
  logic signed [RW-1:0] res;
  logic        [W-1:0]  lg;

  always_comb begin
    xe  = {{2{x_i[W-1]}}, x_i};
    ye  = {{2{y_i[W-1]}}, y_i};
    sum = xe + ye;
    dif = xe - ye;
    lg  = '0;
    res = '0;
    // All shift operands are signed variables, so >>> floors toward -inf.
    case (alu_op_e'(op_i))
      OP_AVG:  res = sum >>> 1;
      OP_DBL:  res = sum <<< 1;
      OP_XHY:  res = xe + (ye >>> 1);
      OP_HDIF: res = dif >>> 1;
      OP_NAND: begin lg = ~(x_i & y_i); res = {{2{lg[W-1]}}, lg}; end
      OP_NOTX: begin lg = ~x_i;         res = {{2{lg[W-1]}}, lg}; end
      OP_NOR:  begin lg = ~(x_i | y_i); res = {{2{lg[W-1]}}, lg}; end
      OP_XOR:  begin lg = x_i ^ y_i;    res = {{2{lg[W-1]}}, lg}; end
      default: res = '0;
    endcase
    result_o = res;
    zero_o   = (res == '0);
    neg_o    = res[RW-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipeline around alu_core: S1 holds operands, S2 holds
// the flagged result; counts results accepted downstream.
module alu_pipe import alu_pkg::*; #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);
  localparam int RW = res_w(W);

  logic             s1_v_q, s1_v_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [RW-1:0]    result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_free, in_fire, s1_adv, out_fire;
  logic [RW-1:0]    core_result;
  logic             core_zero, core_neg;

  alu_core #(.W(W)) u_core (
    .x_i      (x_q),
    .y_i      (y_q),
    .op_i     (op_q),
    .result_o (core_result),
    .zero_o   (core_zero),
    .neg_o    (core_neg)
  );

  // Handshake: a beat moves on any edge where valid && ready. S2 can take a
  // new result when empty or being drained this cycle; S1 likewise relative
  // to S2, so in_ready depends combinationally on out_ready.
  always_comb begin
    s2_free  = !out_valid_q || bus.out_ready;
    in_fire  = bus.in_valid && (!s1_v_q || s2_free);
    s1_adv   = s1_v_q && s2_free;
    out_fire = out_valid_q && bus.out_ready;
  end

  always_comb begin
    s1_v_d      = s1_v_q;
    x_d         = x_q;
    y_d         = y_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    if (in_fire) begin
      s1_v_d = 1'b1;
      x_d    = bus.x;
      y_d    = bus.y;
      op_d   = bus.op;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
    if (s1_adv) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      zero_d      = core_zero;
      neg_d       = core_neg;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (out_fire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = !s1_v_q || s2_free;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.op_count  = cnt_q;

endmodule
